// File: rtl/bg_pkg.sv
// Shared types and slot-phase map for the background fetch sequencer family.
package bg_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } bgState_e;

  // Slot phases at which each memory pipeline event occurs
  localparam int PH_CHAR_ADDR = 0;
  localparam int PH_CHAR_DATA = 1;
  localparam int PH_PAL_ADDR  = 1;
  localparam int PH_TLO_ADDR  = 2;
  localparam int PH_PAL_DATA  = 3;
  localparam int PH_TLO_DATA  = 3;
  localparam int PH_THI_ADDR  = 4;
  localparam int PH_THI_DATA  = 5;

endpackage

// File: rtl/bg_slot_counter.sv
// Phase/slot counters for one line fetch: phase wraps at SLOT_CYCLES, slot steps on wrap.
// Counters freeze on the final phase of the last slot so tile_col holds through IDLE.
module bg_slot_counter #(
  parameter int SLOT_CYCLES = 12,
  parameter int PHASE_W     = 4,
  parameter int SLOT_W      = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
  input  logic [SLOT_W-1:0] lastSlotIdx,
  output logic [PHASE_W-1:0] phase,
  output logic [SLOT_W-1:0] slot,
  output logic              lastCycle
);

  logic phaseWrap;

  assign phaseWrap = (phase == PHASE_W'(SLOT_CYCLES - 1));
  assign lastCycle = phaseWrap && (slot == lastSlotIdx);

  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= '0;
      slot  <= '0;
    end else if (clear) begin
      phase <= '0;
      slot  <= '0;
    end else if (advance && !lastCycle) begin
      if (phaseWrap) begin
        phase <= '0;
        slot  <= slot + SLOT_W'(1);
      end else begin
        phase <= phase + PHASE_W'(1);
      end
    end
  end

endmodule

// File: rtl/bg_fetch_sequencer.sv
// Per-scanline background fetch sequencer: phase strobes decoded from registered state, line_done one cycle after last slot.
// Optional BG_FETCH_MEM_READY_EN: an address strobe with mem_ready low stalls phase/slot and masks latches/pixels.
module bg_fetch_sequencer
  import bg_pkg::*;
#(
  parameter int TILES_PER_LINE = 40,
  parameter int SLOT_CYCLES    = 12,
  parameter int PAN_W          = 4,
  parameter int COL_W          = 6,
  parameter int PIX_FIRST      = 4,
  parameter int PIX_LAST       = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             line_start,
  input  logic [PAN_W-1:0] pan_offset,
  input  logic [COL_W-1:0] scroll_col,
  input  logic             mem_ready,
  output logic             char_addr_strobe,
  output logic             char_data_latch,
  output logic             pal_addr_strobe,
  output logic             tile_lo_addr_strobe,
  output logic             pal_data_latch,
  output logic             tile_lo_data_latch,
  output logic             tile_hi_addr_strobe,
  output logic             tile_hi_data_latch,
  output logic             pixel_valid,
  output logic [COL_W-1:0] tile_col,
  output logic             busy,
  output logic             line_done
);

  localparam int PHASE_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int SLOT_W  = $clog2(TILES_PER_LINE + 2);

  bgState_e state, stateNext;
  logic [PAN_W-1:0]   panLat;
  logic [COL_W-1:0]   scrollLat;
  logic [PHASE_W-1:0] phase;
  logic [SLOT_W-1:0]  slot;
  logic [SLOT_W-1:0]  lastSlotIdx;
  logic lastCycle;
  logic fetching;
  logic advance;
  logic stall;
  logic anyAddrStrobe;
  logic lineDoneReg;
  logic lineDoneNext;
  logic charAddr, charData, palAddr, tloAddr, palData, tloData, thiAddr, thiData, pixWin;

  assign fetching = (state == FETCH);
  assign advance  = fetching && !stall;

  // A nonzero fine pan exposes one extra partial tile, so fetch one more slot
  assign lastSlotIdx = (panLat != '0) ? SLOT_W'(TILES_PER_LINE) : SLOT_W'(TILES_PER_LINE - 1);

  bg_slot_counter #(
    .SLOT_CYCLES(SLOT_CYCLES),
    .PHASE_W    (PHASE_W),
    .SLOT_W     (SLOT_W)
  ) uSlotCounter (
    .clk        (clk),
    .reset      (reset),
    .clear      (line_start),
    .advance    (advance),
    .lastSlotIdx(lastSlotIdx),
    .phase      (phase),
    .slot       (slot),
    .lastCycle  (lastCycle)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      lineDoneReg <= 1'b0;
      panLat      <= '0;
      scrollLat   <= '0;
    end else begin
      state       <= stateNext;
      lineDoneReg <= lineDoneNext;
      if (line_start) begin
        panLat    <= pan_offset;
        scrollLat <= scroll_col;
      end
    end
  end

  always_comb begin
    stateNext    = state;
    lineDoneNext = 1'b0;
    case (state)
      IDLE: begin
        if (line_start) stateNext = FETCH;
      end
      FETCH: begin
        // A restart abandons the current line without signalling completion
        if (line_start) begin
          stateNext = FETCH;
        end else if (advance && lastCycle) begin
          stateNext    = IDLE;
          lineDoneNext = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    charAddr = fetching && (phase == PHASE_W'(PH_CHAR_ADDR));
    charData = fetching && (phase == PHASE_W'(PH_CHAR_DATA));
    palAddr  = fetching && (phase == PHASE_W'(PH_PAL_ADDR));
    tloAddr  = fetching && (phase == PHASE_W'(PH_TLO_ADDR));
    palData  = fetching && (phase == PHASE_W'(PH_PAL_DATA));
    tloData  = fetching && (phase == PHASE_W'(PH_TLO_DATA));
    thiAddr  = fetching && (phase == PHASE_W'(PH_THI_ADDR));
    thiData  = fetching && (phase == PHASE_W'(PH_THI_DATA));
    pixWin   = fetching && (phase >= PHASE_W'(PIX_FIRST)) && (phase <= PHASE_W'(PIX_LAST));
  end

  assign anyAddrStrobe = charAddr || palAddr || tloAddr || thiAddr;

`ifdef BG_FETCH_MEM_READY_EN
  assign stall = anyAddrStrobe && !mem_ready;
`else
  logic unusedMemReady;
  assign unusedMemReady = mem_ready ^ anyAddrStrobe;
  assign stall = 1'b0;
`endif

  // Address strobes stay up through a stall; data/pixel events must not repeat
  assign char_addr_strobe    = charAddr;
  assign pal_addr_strobe     = palAddr;
  assign tile_lo_addr_strobe = tloAddr;
  assign tile_hi_addr_strobe = thiAddr;
  assign char_data_latch     = charData && !stall;
  assign pal_data_latch      = palData && !stall;
  assign tile_lo_data_latch  = tloData && !stall;
  assign tile_hi_data_latch  = thiData && !stall;
  assign pixel_valid         = pixWin && !stall;

  assign tile_col  = scrollLat + COL_W'(slot);
  assign busy      = fetching;
  assign line_done = lineDoneReg;

endmodule

// File: tb/tb_bg_fetch_sequencer.sv
// Directed bench for bg_fetch_sequencer: table of whole-line vectors plus restart/reset/stall sequences.
module tb_bg_fetch_sequencer;
  import bg_pkg::*;

  logic       clk;
  logic       reset;
  logic       line_start;
  logic [3:0] pan_offset;
  logic [5:0] scroll_col;
  logic       mem_ready;
  logic       char_addr_strobe, char_data_latch, pal_addr_strobe, tile_lo_addr_strobe;
  logic       pal_data_latch, tile_lo_data_latch, tile_hi_addr_strobe, tile_hi_data_latch;
  logic       pixel_valid;
  logic [5:0] tile_col;
  logic       busy;
  logic       line_done;

  bg_fetch_sequencer dut (
    .clk                (clk),
    .reset              (reset),
    .line_start         (line_start),
    .pan_offset         (pan_offset),
    .scroll_col         (scroll_col),
    .mem_ready          (mem_ready),
    .char_addr_strobe   (char_addr_strobe),
    .char_data_latch    (char_data_latch),
    .pal_addr_strobe    (pal_addr_strobe),
    .tile_lo_addr_strobe(tile_lo_addr_strobe),
    .pal_data_latch     (pal_data_latch),
    .tile_lo_data_latch (tile_lo_data_latch),
    .tile_hi_addr_strobe(tile_hi_addr_strobe),
    .tile_hi_data_latch (tile_hi_data_latch),
    .pixel_valid        (pixel_valid),
    .tile_col           (tile_col),
    .busy               (busy),
    .line_done          (line_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int chars, pixs, dones;

  typedef struct {
    logic [3:0] pan;
    logic [5:0] scroll;
    int         slots;
    int         doneAt;
    int         pix;
    logic [5:0] lastCol;
  } vec_t;

  vec_t vecs[5];

  // {char_addr, char_data, pal_addr, tlo_addr, pal_data, tlo_data, thi_addr, thi_data, pixel_valid}
  function automatic logic [8:0] phaseVec(input int p);
    case (p)
      0:       return 9'b100000000;
      1:       return 9'b011000000;
      2:       return 9'b000100000;
      3:       return 9'b000011000;
      4:       return 9'b000000101;
      5:       return 9'b000000011;
      6, 7, 8, 9, 10, 11: return 9'b000000001;
      default: return 9'b000000000;
    endcase
  endfunction

  function automatic logic [16:0] obs();
    return {busy, line_done, char_addr_strobe, char_data_latch, pal_addr_strobe,
            tile_lo_addr_strobe, pal_data_latch, tile_lo_data_latch,
            tile_hi_addr_strobe, tile_hi_data_latch, pixel_valid, tile_col};
  endfunction

  // Expected outputs c cycles after the line_start edge
  function automatic logic [16:0] model(input int c, input int scroll, input int slots, input int doneAt);
    logic [5:0] col;
    if (c >= 1 && c < doneAt) begin
      col = 6'((scroll + (c - 1) / 12) % 64);
      return {1'b1, 1'b0, phaseVec((c - 1) % 12), col};
    end
    col = 6'((scroll + slots - 1) % 64);
    return {1'b0, (c == doneAt), 9'b0, col};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scan(input string name, input int fromC, input int toC, input int scroll,
                      input int slots, input int doneAt, input int off);
    for (int c = fromC; c <= toC; c++) begin
      tick();
      line_start = 1'b0;
      pan_offset = 4'($urandom);
      scroll_col = 6'($urandom);
`ifndef BG_FETCH_MEM_READY_EN
      mem_ready = 1'($urandom);
`endif
      @(negedge clk);
      check($sformatf("%s c=%0d", name, c), 32'(obs()), 32'(model(c - off, scroll, slots, doneAt)));
      chars += int'(char_addr_strobe);
      pixs  += int'(pixel_valid);
      dones += int'(line_done);
    end
  endtask

  task automatic startLine(input logic [3:0] pan, input logic [5:0] scroll);
    tick();
    line_start = 1'b1;
    pan_offset = pan;
    scroll_col = scroll;
    chars = 0;
    pixs  = 0;
    dones = 0;
  endtask

  task automatic runRow(input int i);
    string nm;
    nm = $sformatf("row%0d", i);
    startLine(vecs[i].pan, vecs[i].scroll);
    scan(nm, 1, vecs[i].doneAt + 10, int'(vecs[i].scroll), vecs[i].slots, vecs[i].doneAt, 0);
    check({nm, " char strobes"}, 32'(chars), 32'(vecs[i].slots));
    check({nm, " pixel cycles"}, 32'(pixs), 32'(vecs[i].pix));
    check({nm, " line_done count"}, 32'(dones), 32'd1);
    check({nm, " held tile_col"}, 32'(tile_col), 32'(vecs[i].lastCol));
  endtask

  initial begin
    reset      = 1'b1;
    line_start = 1'b0;
    pan_offset = '0;
    scroll_col = '0;
    mem_ready  = 1'b1;

    vecs[0] = '{4'd0,  6'd0,  40, 481, 320, 6'd39};
    vecs[1] = '{4'd5,  6'd60, 41, 493, 328, 6'd36};
    vecs[2] = '{4'd15, 6'd63, 41, 493, 328, 6'd39};
    vecs[3] = '{4'd0,  6'd25, 40, 481, 320, 6'd0};
    vecs[4] = '{4'd1,  6'd10, 41, 493, 328, 6'd50};

    repeat (3) tick();
    @(negedge clk);
    check("reset outputs", 32'(obs()), 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("idle after reset", 32'(obs()), 32'd0);

    for (int i = 0; i < 5; i++) runRow(i);

    // Restart mid-line: only the second line completes
    startLine(4'd0, 6'd7);
    scan("restartA", 1, 99, 7, 40, 481, 0);
    tick();
    line_start = 1'b1;
    pan_offset = 4'd0;
    scroll_col = 6'd30;
    @(negedge clk);
    check("restart c=100", 32'(obs()), 32'(model(100, 7, 40, 481)));
    scan("restartB", 1, 491, 30, 40, 481, 0);
    check("restart line_done count", 32'(dones), 32'd1);

    // Reset during a line
    startLine(4'd3, 6'd12);
    scan("midrst", 1, 49, 12, 41, 493, 0);
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("midrst c=50", 32'(obs()), 32'(model(50, 12, 41, 493)));
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("midrst cleared", 32'(obs()), 32'd0);
    dones = 0;
    scan("midrst idle", 1, 500, 0, 1, 0, 0);
    check("midrst no line_done", 32'(dones), 32'd0);
    runRow(1);

    // Reset wins over a coincident line_start
    tick();
    reset      = 1'b1;
    line_start = 1'b1;
    pan_offset = 4'd2;
    scroll_col = 6'd9;
    tick();
    reset      = 1'b0;
    line_start = 1'b0;
    @(negedge clk);
    check("coincident reset", 32'(obs()), 32'd0);
    dones = 0;
    scan("coinc idle", 1, 20, 0, 1, 0, 0);
    check("coinc no line_done", 32'(dones), 32'd0);

`ifdef BG_FETCH_MEM_READY_EN
    // Three-cycle stall on the first tile_hi address strobe
    startLine(4'd0, 6'd0);
    scan("stallA", 1, 4, 0, 40, 481, 0);
    for (int c = 5; c <= 8; c++) begin
      tick();
      line_start = 1'b0;
      mem_ready  = (c == 8);
      @(negedge clk);
      check($sformatf("stall c=%0d", c), 32'(obs()),
            (c == 8) ? 32'(model(5, 0, 40, 481)) : 32'({1'b1, 1'b0, 9'b000000100, 6'd0}));
    end
    scan("stallB", 9, 494, 0, 40, 481, 3);
    check("stall line_done count", 32'(dones), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bg_fetch_sequencer.md
Name: bg_fetch_sequencer

Overview:
Per-scanline fetch sequencer for one background layer. It is the parametrised successor of the fixed 40-tile, 12-cycle background control pipeline. It issues per-tile-slot strobes for the char/palette/tile-low/tile-high memory pipeline and a pixel-valid window, and generates a wrapped tile-column address from a coarse scroll value. Sits between the video timing generator (line_start) and the background memory arbiter / pixel shifter.

Parameters:
TILES_PER_LINE, 40, visible tile slots per line (an extra slot is fetched when fine pan is nonzero)
SLOT_CYCLES, 12, clocks per tile slot; must be >= 6 and >= PIX_LAST+1
PAN_W, 4, fine pan offset width
COL_W, 6, tile column address width; map width is 2**COL_W and the column wraps at that width
PIX_FIRST, 4, first slot phase with pixel_valid high
PIX_LAST, 11, last slot phase with pixel_valid high

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
line_start  in  1  one-cycle pulse that begins a line fetch
pan_offset  in  PAN_W  fine pan; sampled on line_start
scroll_col  in  COL_W  coarse scroll column; sampled on line_start
mem_ready  in  1  memory accepts the current address strobe (used only with the optional feature)
char_addr_strobe  out  1  slot phase 0
char_data_latch  out  1  phase 1
pal_addr_strobe  out  1  phase 1
tile_lo_addr_strobe  out  1  phase 2
pal_data_latch  out  1  phase 3
tile_lo_data_latch  out  1  phase 3
tile_hi_addr_strobe  out  1  phase 4
tile_hi_data_latch  out  1  phase 5
pixel_valid  out  1  phase in [PIX_FIRST, PIX_LAST]
tile_col  out  COL_W  column of the current slot
busy  out  1  high while in FETCH
line_done  out  1  one-cycle pulse after the last slot

Behaviour:
- States: IDLE, FETCH. No other states.
- Reset: the state is IDLE and phase, slot and latched registers are 0. All outputs read 0.
- line_start sampled high on edge k, in any state:
  - latch pan_offset and scroll_col
  - set phase=0 and slot=0
  - state becomes FETCH
  - char_addr_strobe is high in cycle k+1
- A line_start during FETCH restarts the line at once. No line_done is issued for the aborted line.
- Slot count N = TILES_PER_LINE + (pan_lat != 0).
- In FETCH, phase advances by 1 each cycle. When phase reaches SLOT_CYCLES-1 it wraps to 0 and slot increments.
- Leaving FETCH:
  - After phase SLOT_CYCLES-1 of slot N-1, the state returns to IDLE.
  - line_done pulses high for exactly that next cycle. busy is low in that same cycle.
- Phase strobes: each is asserted only in FETCH and only at its stated phase. They are decoded combinationally from registered phase/state. All are 0 in IDLE.
- tile_col = (scroll_lat + slot) mod 2**COL_W. It wraps naturally via COL_W-bit addition and holds its last value in IDLE.
- Default timing: N=40 gives 480 FETCH cycles and line_done at k+481. N=41 gives 492 cycles and line_done at k+493.
- Mid-operation reset forces IDLE on the next edge. No line_done is issued.
- line_start coincident with reset: reset wins.

Optional Feature:
BG_FETCH_MEM_READY_EN
- Defined:
  - In any cycle where an address strobe (char, pal, tile_lo, tile_hi) is high and mem_ready=0, phase and slot hold. The strobe stays high.
  - pixel_valid and all data_latch outputs are forced low during the stall.
  - Advance resumes on the first cycle with mem_ready=1.
- Undefined: mem_ready is ignored and timing is fixed as above.

Decomposition:
- Shared package bg_pkg:
  - state enum (IDLE, FETCH)
  - phase index constants (PH_CHAR_ADDR=0, PH_CHAR_DATA=1, PH_PAL_ADDR=1, PH_TLO_ADDR=2, PH_PAL_DATA=3, PH_TLO_DATA=3, PH_THI_ADDR=4, PH_THI_DATA=5)
- One natural sub-module: bg_slot_counter. It holds the phase/slot counters with wrap, hold (stall) and the last-slot flag. The top level keeps the FSM, latches and strobe decode.

Test Plan:
- Reset then a single line_start with pan=0 and scroll=0 (default parameters) -> 40 char_addr_strobe pulses 12 cycles apart; 320 pixel_valid cycles; line_done only at k+481; tile_col runs 0..39.
- pan=5, scroll=60 -> 41 slots; tile_col sequence 60,61,62,63,0,1,…,36; line_done at k+493.
- line_start again at k+100 -> restart from slot 0 with the new scroll; only one line_done, at (k+100)+481.
- reset asserted at k+50 -> all outputs 0 at k+51; no line_done; next line_start behaves normally.
- With BG_FETCH_MEM_READY_EN, mem_ready=0 for 3 cycles at the first tile_hi_addr_strobe -> strobe high for 4 cycles; pixel_valid low during the stall; line_done delayed by exactly 3 cycles.
- Without the macro, mem_ready randomised -> timing identical to the first scenario.
